fixed_p_mult_share_arb: RTL

Shares one pipelined unsigned fixed-point multiplier among num_req Calyx-style go/done requesters. Selection is round-robin.
- Sits between several group-level fixed_p_std_mult users and a single multiplier datapath.
- Issues at most one operation per cycle; operations from different requesters overlap in the pipeline.
- Each requester sees a fixed 3-cycle go-to-done latency once it is granted.

---
 rtl/fixed_p_pkg.sv | 33 +++
 rtl/rr_arbiter.sv | 69 ++++++
 rtl/fixed_p_mult_share_arb.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/fixed_p_pkg.sv
// Shared helpers for the shared fixed-point multiplier.
// Purpose: product width, result/overflow slice bounds and requester-id width,
//          so the top and the arbiter derive their sizes the same way.
// Ports:   none (package).
package fixed_p_pkg;

    // Full unsigned product of two width-bit operands.
    function automatic int unsigned prod_width(input int unsigned width);
        return 2 * width;
    endfunction

    // Result slice: drop fract_width fraction bits, keep width bits above them.
    function automatic int unsigned res_hi(input int unsigned width,
                                           input int unsigned fract_width);
        return width + fract_width - 1;
    endfunction

    function automatic int unsigned res_lo(input int unsigned fract_width);
        return fract_width;
    endfunction

    // Lowest discarded product bit that signals overflow.
    function automatic int unsigned ovf_lo(input int unsigned width,
                                           input int unsigned fract_width);
        return width + fract_width;
    endfunction

    // Requester index width, never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned num_req);
        return (num_req <= 1) ? 1 : $clog2(num_req);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for the shared multiplier.
// Purpose: pick the first eligible requester searching circularly from the
//          index after the last grant; at most one grant per cycle.
// Ports:
//   clk        - clock
//   reset      - asynchronous active-high reset (pointer -> num_req-1)
//   eligible   - per-requester eligibility this cycle
//   advance    - a grant is being taken; pointer moves to grant_idx
//   grant      - one-hot grant (or zero)
//   grant_idx  - index of the granted requester (0 when no grant)
module rr_arbiter
    import fixed_p_pkg::*;
#(
    parameter int unsigned num_req = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [num_req-1:0]               eligible,
    input  logic                             advance,
    output logic [num_req-1:0]               grant,
    output logic [id_width(num_req)-1:0]     grant_idx
);

    localparam int unsigned IdW = id_width(num_req);

    logic [IdW-1:0] ptr_q;
    logic [IdW-1:0] ptr_d;
    logic [IdW-1:0] cand_idx;
    int unsigned    cand;
    logic           found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        // Search ptr+1 .. ptr+num_req (mod num_req); the last probed index is
        // the pointer itself, so a lone requester can win back-to-back.
        for (int unsigned k = 1; k <= num_req; k++) begin
            cand = 32'(ptr_q) + k;
            if (cand >= num_req) begin
                cand = cand - num_req;
            end
            cand_idx = IdW'(cand);
            if (!found && eligible[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = grant_idx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= IdW'(num_req - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fixed_p_mult_share_arb.sv
// Shared pipelined unsigned fixed-point multiplier with go/done requesters.
// Purpose: round-robin arbitrates num_req requesters onto one 3-stage
//          multiplier; each granted request completes exactly 3 cycles later.
// Ports:
//   clk       - clock, all state on rising edge
//   reset     - asynchronous active-high reset
//   go        - per-requester request, held until that requester's done
//   left      - flattened left operands, requester i at [i*width +: width]
//   right     - flattened right operands, same packing
//   out       - truncated result, valid while some done bit is high, else held
//   done      - one-cycle completion pulse per requester
//   overflow  - discarded upper product bits nonzero, qualified by done
//   busy      - some pipeline stage holds a valid operation
module fixed_p_mult_share_arb
    import fixed_p_pkg::*;
#(
    parameter int unsigned width       = 32,
    parameter int unsigned int_width   = 8,
    parameter int unsigned fract_width = 24,
    parameter int unsigned num_req     = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [num_req-1:0]         go,
    input  logic [num_req*width-1:0]   left,
    input  logic [num_req*width-1:0]   right,
    output logic [width-1:0]           out,
    output logic [num_req-1:0]         done,
    output logic                       overflow,
    output logic                       busy
);

    localparam int unsigned ProdW = prod_width(width);
    localparam int unsigned ResHi = res_hi(width, fract_width);
    localparam int unsigned ResLo = res_lo(fract_width);
    localparam int unsigned OvfLo = ovf_lo(width, fract_width);
    localparam int unsigned IdW   = id_width(num_req);

    if (int_width + fract_width != width) begin : g_bad_format
        $error("fixed_p_mult_share_arb: int_width + fract_width must equal width");
    end
    if (num_req < 2 || num_req > 16) begin : g_bad_num_req
        $error("fixed_p_mult_share_arb: num_req must be in 2..16");
    end

    // Unpacked views of the flattened operand buses.
    logic [width-1:0] left_arr  [num_req];
    logic [width-1:0] right_arr [num_req];
    for (genvar g = 0; g < num_req; g++) begin : g_unpack
        assign left_arr[g]  = left[g*width +: width];
        assign right_arr[g] = right[g*width +: width];
    end

    logic [num_req-1:0] eligible;
    logic [num_req-1:0] grant;
    logic [IdW-1:0]     grant_idx;
    logic               grant_any;

    logic [num_req-1:0] inflight_q, inflight_d;
    logic [num_req-1:0] done_q, done_d;

    logic               s1_valid_q, s2_valid_q;
    logic [IdW-1:0]     s1_id_q, s2_id_q;
    logic [width-1:0]   s1_l_q, s1_r_q;
    logic [ProdW-1:0]   prod;
    logic [ProdW-1:0]   s2_prod_q;
    logic [width-1:0]   out_q;
    logic               ovf_q;

    // done_q blocks a regrant in the completion cycle while go is still high.
    assign eligible  = go & ~inflight_q & ~done_q;
    assign grant_any = |grant;

    rr_arbiter #(
        .num_req (num_req)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .eligible  (eligible),
        .advance   (grant_any),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign prod = ProdW'(s1_l_q) * ProdW'(s1_r_q);

    // Fraction bits below the result slice are truncated away.
    logic unused_prod_lo;
    assign unused_prod_lo = ^s2_prod_q[ResLo-1:0];

    always_comb begin
        inflight_d = inflight_q;
        if (s2_valid_q) begin
            inflight_d[s2_id_q] = 1'b0;
        end
        if (grant_any) begin
            inflight_d[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        done_d = '0;
        if (s2_valid_q) begin
            done_d[s2_id_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight_q <= '0;
            s1_valid_q <= 1'b0;
            s1_id_q    <= '0;
            s1_l_q     <= '0;
            s1_r_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_id_q    <= '0;
            s2_prod_q  <= '0;
            done_q     <= '0;
            out_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;

            // Stage 1: capture operands at issue; later operand changes are ignored.
            s1_valid_q <= grant_any;
            if (grant_any) begin
                s1_id_q <= grant_idx;
                s1_l_q  <= left_arr[grant_idx];
                s1_r_q  <= right_arr[grant_idx];
            end

            // Stage 2: full-width product.
            s2_valid_q <= s1_valid_q;
            s2_id_q    <= s1_id_q;
            s2_prod_q  <= prod;

            // Stage 3: result and overflow hold between completions.
            done_q <= done_d;
            if (s2_valid_q) begin
                out_q <= s2_prod_q[ResHi:ResLo];
                ovf_q <= |s2_prod_q[ProdW-1:OvfLo];
            end
        end
    end

    assign out      = out_q;
    assign done     = done_q;
    assign overflow = ovf_q;
    assign busy     = s1_valid_q | s2_valid_q | (|done_q);

endmodule
